perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised, memory-mapped performance counter bank for the LC-3b pipelined CPU. It generalises the fixed set of per-event counters into NUM_CH identical channels, each with a programmable mode, run-length threshold and sticky overflow flag, plus a global freeze. It sits on the data-memory side of the MEM stage. It decodes a word-aligned address window, answers loads from that window in the same cycle, and passes all other read data through untouched.

## Interface
- NUM_CH, 9: number of counter channels (1..32).
- WIDTH, 16: counter width in bits (1..16); reads are zero-extended to 16.
- BASE_ADDR, 16'hFF00: first byte address of the window; must be 4-byte aligned.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- trigger  in  NUM_CH  per-channel event inputs, sampled every cycle.
- mem_address  in  16  data address from the MEM stage.
- mem_read  in  1  load strobe.
- mem_write  in  1  store strobe.
- mem_wdata  in  16  store data.
- mem_byte_enable  in  2  store byte lanes.
- mem_rdata_in  in  16  read data from the data cache.
- mem_rdata_out  out  16  muxed read data to the MEM stage.
- hit  out  1  mem_address is inside the window.

## Operation
- Window layout:
  - Channel i count word at BASE_ADDR+4i: read returns the count; any write clears the count and its overflow flag.
  - Channel i config word at BASE_ADDR+4i+2: bit0 = mode (0 cycle, 1 event); bit1 = overflow (read-only); bits[15:8] = thresh; other bits read 0.
  - Control word at BASE_ADDR+4*NUM_CH: bit0 = freeze (R/W); other bits read 0.
- hit is 1 for addresses BASE_ADDR .. BASE_ADDR+4*NUM_CH+1 inclusive. mem_address[0] is ignored inside the window.
- Read path: mem_rdata_out = window word when hit && mem_read, else mem_rdata_in. The path is combinational.
- Config and control writes honour mem_byte_enable per byte. Count-word writes clear regardless of the enables.
- Each channel keeps run_len (8 bits, saturating at 255):
  - trigger high: run_len increments; trigger low: run_len returns to 0.
  - "Qualified" means trigger is high and run_len >= thresh, where run_len is the value before this edge.
- Cycle mode: count increments on every qualified cycle.
- Event mode: count increments once per run, in the cycle where trigger is high and run_len == thresh. It does not re-count while the run continues, and a run saturated at 255 does not re-count.
- freeze=1: counts and overflow flags hold; run_len keeps tracking.
- Overflow without PERF_SAT_EN: increment at all-ones wraps to 0 and sets overflow.
- Simultaneous clear-write and increment on a channel: the clear wins (count 0, overflow 0).
- Simultaneous load and store to the same word: the load returns the pre-edge value.
- Writes into the window with mem_read=0 still take effect. Stores outside the window have no effect.

## Timing
- Reset values: all counts 0, overflow 0, mode 0, thresh 0, run_len 0, freeze 0.
  - mem_rdata_out then equals mem_rdata_in unless a read hits, in which case it returns zero window state.
  - hit is purely combinational from mem_address.
- Latency:
  - A trigger asserted in cycle n is visible in the count read in cycle n+1.
  - A write in cycle n takes effect at the edge ending cycle n; a read in n+1 sees it.
- reset asserted in the same cycle as a write or trigger: reset wins.
- No handshake or stall: the block never back-pressures the MEM stage.

## Configuration
- PERF_SAT_EN defined: counts saturate at all-ones. An increment attempted at all-ones leaves the count at all-ones and sets overflow.
- PERF_SAT_EN undefined: wrap-to-0 behaviour as in Operation.

## Structure
- In lc3b_types:
  - perf_mode_t enum {perf_cycle, perf_event}.
  - perf_cfg_t packed struct {thresh[7:0], overflow, mode}.
  - Word-offset constants for count, config and control.
- One sub-module, perf_channel, instantiated NUM_CH times via generate.
  - Holds count, run_len and cfg.
  - Inputs: clk, reset, trigger, freeze, clear, cfg write data and byte enables.
- The top level holds address decode, the freeze register and the read mux.

## Test plan
- Reset, then hold trigger[0] high 5 cycles (cycle mode, thresh 0) -> count word 0 reads 5; mem_rdata_out = mem_rdata_in for address 16'h0100.
- Ch1 event mode, thresh 2; pulses of 1, 3 and 6 cycles -> count 2.
- Ch2 WIDTH=4, cycle mode, 17 trigger cycles:
  - Without PERF_SAT_EN -> count 1, overflow 1.
  - With PERF_SAT_EN -> count 15, overflow 1.
- Set freeze, trigger ch0 10 cycles, clear freeze -> count unchanged. Store to count word 0 in the same cycle as trigger high -> count 0.
- Byte-enable 2'b10 write of 16'h0301 to ch3 config -> thresh 3, mode unchanged 0. Assert reset mid-run -> all words read 0 next cycle.

Source files
------------

// File: rtl/lc3b_types.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : lc3b_types                                                   |
// | Shared types and address-map constants for the LC-3b performance       |
// | counter bank (channel mode, packed channel config, word offsets).      |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package lc3b_types;

  typedef enum logic {
    perf_cycle = 1'b0,
    perf_event = 1'b1
  } perf_mode_t;

  typedef struct packed {
    logic [7:0] thresh;
    logic       overflow;
    perf_mode_t mode;
  } perf_cfg_t;

  // Byte offsets inside one channel's 4-byte slot, and the slot stride
  localparam logic [1:0] PERF_OFS_COUNT  = 2'd0;
  localparam logic [1:0] PERF_OFS_CONFIG = 2'd2;
  localparam int         PERF_CH_STRIDE  = 4;

  // Run-length counter saturates here
  localparam logic [7:0] PERF_RUN_MAX = 8'hFF;

  // Control word sits directly after the last channel slot
  function automatic logic [15:0] perf_ctrl_offset(input int num_ch);
    return 16'(PERF_CH_STRIDE * num_ch);
  endfunction

  // Bus image of a channel config word: thresh in the high byte
  function automatic logic [15:0] perf_cfg_word(input perf_cfg_t cfg);
    return {cfg.thresh, 6'b000000, cfg.overflow, cfg.mode};
  endfunction

endpackage
`default_nettype wire

// File: rtl/perf_channel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : perf_channel                                                 |
// | One performance-counter channel: event counter, run-length tracker,    |
// | mode/threshold config and sticky overflow flag.                        |
// | Build option: define PERF_SAT_EN to saturate instead of wrapping.      |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module perf_channel
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic             freeze,
  input  logic             clear,
  input  logic [15:0]      cfg_wdata,
  input  logic [1:0]       cfg_be,
  output logic [WIDTH-1:0] count,
  output perf_cfg_t        cfg
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [7:0]       run_len;
  logic             sat_hold;
  perf_cfg_t        cfg_q;
  logic             qualified;
  logic             at_thresh;
  logic             inc;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, cfg_wdata[7:1]};

  // Decide whether this edge increments the count
  always_comb begin
    qualified = trigger && (run_len >= cfg_q.thresh);
    // sat_hold marks a run parked at 255, so it is not counted again
    at_thresh = trigger && (run_len == cfg_q.thresh) && !sat_hold;
    inc       = !freeze && ((cfg_q.mode == perf_event) ? at_thresh : qualified);
  end

  // Run-length tracking continues even while frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      run_len  <= 8'd0;
      sat_hold <= 1'b0;
    end else begin
      if (!trigger) begin
        run_len <= 8'd0;
      end else if (run_len != PERF_RUN_MAX) begin
        run_len <= run_len + 8'd1;
      end
      sat_hold <= trigger && (run_len == PERF_RUN_MAX);
    end
  end

  // Count, overflow and config; clear beats increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      cfg_q   <= '{thresh: 8'd0, overflow: 1'b0, mode: perf_cycle};
    end else begin
      if (clear) begin
        count_q        <= '0;
        cfg_q.overflow <= 1'b0;
      end else if (inc) begin
        if (count_q == COUNT_MAX) begin
`ifdef PERF_SAT_EN
          count_q <= COUNT_MAX;
`else
          count_q <= '0;
`endif
          cfg_q.overflow <= 1'b1;
        end else begin
          count_q <= count_q + COUNT_ONE;
        end
      end
      if (cfg_be[0]) begin
        cfg_q.mode <= perf_mode_t'(cfg_wdata[0]);
      end
      if (cfg_be[1]) begin
        cfg_q.thresh <= cfg_wdata[15:8];
      end
    end
  end

  assign count = count_q;
  assign cfg   = cfg_q;

endmodule
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : perf_counter_bank                                            |
// | Memory-mapped bank of NUM_CH performance counters on the MEM-stage     |
// | data path: window decode, global freeze and combinational read mux.    |
// | Build option: PERF_SAT_EN (saturating counters, see perf_channel).     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module perf_counter_bank
  import lc3b_types::*;
#(
  parameter int          NUM_CH    = 9,
  parameter int          WIDTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trigger,
  input  logic [15:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_wdata,
  input  logic [1:0]        mem_byte_enable,
  input  logic [15:0]       mem_rdata_in,
  output logic [15:0]       mem_rdata_out,
  output logic              hit
);

  localparam logic [15:0] WIN_BYTES = perf_ctrl_offset(NUM_CH) + 16'd2;
  localparam logic [13:0] CTRL_WORD = 14'(NUM_CH);

  logic [15:0]      offset;
  logic [13:0]      word_idx;
  logic             is_cfg;
  logic             is_ctrl;
  logic             store;
  logic             freeze;
  logic [15:0]      win_rdata;
  logic [WIDTH-1:0] counts [NUM_CH];
  perf_cfg_t        cfgs   [NUM_CH];
  logic             unused_addr_bit;

  // Unsigned offset: addresses below BASE_ADDR wrap high and miss
  assign offset          = mem_address - BASE_ADDR;
  assign hit             = (offset < WIN_BYTES);
  assign word_idx        = offset[15:2];
  assign is_cfg          = (offset[1:0] & 2'b10) == PERF_OFS_CONFIG;
  assign is_ctrl         = (word_idx == CTRL_WORD);
  assign store           = hit && mem_write;
  assign unused_addr_bit = offset[0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = store && (word_idx == 14'(i));

    perf_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .trigger   (trigger[i]),
      .freeze    (freeze),
      .clear     (sel && !is_cfg),
      .cfg_wdata (mem_wdata),
      .cfg_be    ((sel && is_cfg) ? mem_byte_enable : 2'b00),
      .count     (counts[i]),
      .cfg       (cfgs[i])
    );
  end

  // Global freeze bit in the control word, low byte lane only
  always_ff @(posedge clk) begin
    if (reset) begin
      freeze <= 1'b0;
    end else if (store && is_ctrl && mem_byte_enable[0]) begin
      freeze <= mem_wdata[0];
    end
  end

  // Window read mux; loads outside the window pass cache data through
  always_comb begin
    win_rdata = 16'h0000;
    for (int i = 0; i < NUM_CH; i++) begin
      if (word_idx == 14'(i)) begin
        win_rdata = is_cfg ? perf_cfg_word(cfgs[i]) : 16'(counts[i]);
      end
    end
    if (is_ctrl) begin
      win_rdata = {15'b0, freeze};
    end
    mem_rdata_out = (hit && mem_read) ? win_rdata : mem_rdata_in;
  end

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_perf_counter_bank                                         |
// | Scoreboard bench: stimulus pushes expected bus responses computed by   |
// | a behavioural model, a negedge monitor pops and compares.              |
// | Honours PERF_SAT_EN like the design.                                   |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_perf_counter_bank;

  localparam int          NUM_CH = 9;
  localparam int          WIDTH  = 4;
  localparam logic [15:0] BASE   = 16'hFF00;
  localparam int          WIN    = 4 * NUM_CH + 2;
  localparam int          CMAX   = (1 << WIDTH) - 1;
`ifdef PERF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] trigger;
  logic [15:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_byte_enable;
  logic [15:0]       mem_rdata_in;
  logic [15:0]       mem_rdata_out;
  logic              hit;

  perf_counter_bank #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .trigger         (trigger),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata_in    (mem_rdata_in),
    .mem_rdata_out   (mem_rdata_out),
    .hit             (hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        hit;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model: true (unbounded) run length, plain integer counts
  int          m_cnt [NUM_CH];
  bit          m_ovf [NUM_CH];
  bit          m_mode[NUM_CH];
  logic [7:0]  m_thr [NUM_CH];
  int          m_run [NUM_CH];
  bit          m_frz;
  logic [NUM_CH-1:0] trig;

  function automatic logic [15:0] cnt_addr(input int ch);
    return BASE + 16'(4 * ch);
  endfunction

  function automatic logic [15:0] cfg_addr(input int ch);
    return BASE + 16'(4 * ch + 2);
  endfunction

  function automatic logic [15:0] ctrl_addr();
    return BASE + 16'(4 * NUM_CH);
  endfunction

  function automatic bit in_win(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return int'(off) < WIN;
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] a);
    logic [15:0] off;
    int w;
    off = a - BASE;
    w   = int'(off) / 4;
    if (w == NUM_CH) return {15'b0, m_frz};
    if (off[1]) return {m_thr[w], 6'b0, m_ovf[w], m_mode[w]};
    return 16'(m_cnt[w]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_ovf[c] = 0; m_mode[c] = 0; m_thr[c] = 8'd0; m_run[c] = 0;
    end
    m_frz = 0;
  endtask

  task automatic model_edge(input logic [NUM_CH-1:0] t, input logic [15:0] a, input logic w,
                            input logic [15:0] wd, input logic [1:0] be, input logic rs);
    logic [15:0] off;
    int  wi;
    bit  inw, cfgw, inc;
    if (rs) begin
      model_reset();
      return;
    end
    off  = a - BASE;
    inw  = in_win(a);
    wi   = int'(off) / 4;
    cfgw = off[1];
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_mode[c]) inc = t[c] && (m_run[c] == int'(m_thr[c]));
      else           inc = t[c] && ((m_run[c] > 255 ? 255 : m_run[c]) >= int'(m_thr[c]));
      if (m_frz) inc = 0;
      if (w && inw && !cfgw && wi == c) begin
        m_cnt[c] = 0; m_ovf[c] = 0;
      end else if (inc) begin
        if (m_cnt[c] == CMAX) begin
          m_ovf[c] = 1;
          m_cnt[c] = SAT ? CMAX : 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
      m_run[c] = t[c] ? (m_run[c] < 1000 ? m_run[c] + 1 : m_run[c]) : 0;
    end
    if (w && inw && cfgw && wi < NUM_CH) begin
      if (be[0]) m_mode[wi] = wd[0];
      if (be[1]) m_thr[wi]  = wd[15:8];
    end
    if (w && inw && wi == NUM_CH && be[0]) m_frz = wd[0];
  endtask

  // One bus cycle: drive, predict, advance model at the edge
  task automatic step(input logic [15:0] a, input logic r, input logic w,
                      input logic [15:0] wd, input logic [1:0] be, input logic rs);
    exp_t e;
    logic [15:0] rin;
    rin             = 16'($urandom);
    trigger         = trig;
    mem_address     = a;
    mem_read        = r;
    mem_write       = w;
    mem_wdata       = wd;
    mem_byte_enable = be;
    mem_rdata_in    = rin;
    reset           = rs;
    e.addr  = a;
    e.hit   = in_win(a);
    e.rdata = (e.hit && r) ? model_word(a) : rin;
    sb.push_back(e);
    @(posedge clk);
    model_edge(trig, a, w, wd, be, rs);
    #1;
  endtask

  task automatic rd(input logic [15:0] a);
    step(a, 1'b1, 1'b0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    step(a, 1'b0, 1'b1, d, be, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) rd(16'h0100);
  endtask

  // Monitor: the bus response is valid every cycle by mid-cycle
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        vectors++;
        if (mem_rdata_out !== mon_e.rdata || hit !== mon_e.hit) begin
          miscompares++;
          $display("FAIL bus addr=%h: got rdata=%h hit=%b, want rdata=%h hit=%b",
                   mon_e.addr, mem_rdata_out, hit, mon_e.rdata, mon_e.hit);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pick;
    logic [15:0] a;
    model_reset();
    trig = '0;
    reset = 1'b1; trigger = '0; mem_address = 16'h0100; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = 16'h0; mem_byte_enable = 2'b00; mem_rdata_in = 16'h0;
    @(posedge clk);
    #1;
    step(16'h0100, 1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    // Reset state of every word class
    rd(cnt_addr(0)); rd(cfg_addr(0)); rd(ctrl_addr());
    // Ch0 cycle mode, 5 trigger cycles
    trig[0] = 1'b1; idle(5); trig[0] = 1'b0;
    rd(cnt_addr(0)); rd(16'h0100);
    // Ch1 event mode thresh 2; pulses of 1, 3, 6 cycles
    wr(cfg_addr(1), 16'h0201, 2'b11);
    trig[1] = 1'b1; idle(1); trig[1] = 1'b0; idle(2);
    trig[1] = 1'b1; idle(3); trig[1] = 1'b0; idle(2);
    trig[1] = 1'b1; idle(6); trig[1] = 1'b0;
    rd(cnt_addr(1)); rd(cfg_addr(1));
    // Ch2 wraps/saturates after 17 cycles
    trig[2] = 1'b1; idle(17); trig[2] = 1'b0;
    rd(cnt_addr(2)); rd(cfg_addr(2));
    // Freeze holds counts
    wr(ctrl_addr(), 16'h0001, 2'b01); rd(ctrl_addr());
    trig[0] = 1'b1; idle(10); trig[0] = 1'b0;
    wr(ctrl_addr(), 16'h0000, 2'b01);
    rd(cnt_addr(0));
    // Clear beats a simultaneous increment
    trig[0] = 1'b1; wr(cnt_addr(0), 16'hFFFF, 2'b00); trig[0] = 1'b0;
    rd(cnt_addr(0)); rd(cfg_addr(2));
    // High-byte-only config write
    wr(cfg_addr(3), 16'h0301, 2'b10); rd(cfg_addr(3));
    // Event mode at thresh 255 counts once despite a saturated run
    wr(cfg_addr(4), 16'hFF01, 2'b11);
    trig[4] = 1'b1; idle(300); trig[4] = 1'b0;
    rd(cnt_addr(4));
    // Window boundaries
    rd(BASE - 16'd2); rd(BASE - 16'd1); rd(BASE + 16'd1);
    rd(ctrl_addr() + 16'd1); rd(ctrl_addr() + 16'd2);
    // Reset mid-run
    trig = '1; idle(3);
    step(cnt_addr(0), 1'b1, 1'b0, 16'h0, 2'b00, 1'b1);
    trig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd(cnt_addr(c)); rd(cfg_addr(c));
    end
    rd(ctrl_addr());
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0) trig[c] = ~trig[c];
      end
      pick = int'($urandom_range(0, 7));
      if (pick <= 4)      a = BASE + 16'($urandom_range(0, WIN - 1));
      else if (pick == 5) a = ($urandom_range(0, 1) == 0) ? BASE - 16'd1 : BASE + 16'(WIN);
      else                a = 16'($urandom);
      step(a, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           {5'b0, 3'($urandom_range(0, 5)), 8'($urandom)}, 2'($urandom),
           $urandom_range(0, 499) == 0);
    end
    trig = '0;
    for (int c = 0; c < NUM_CH; c++) rd(cnt_addr(c));
    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending responses, want 0", sb.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
